// File: rtl/issue_queue.sv
// In-order circular instruction queue between the frontend selector and issue logic; one-cycle flush.
// Push-to-head latency 1 cycle; ready_o/valid_o/count_o come from registered state only, with no pass-through when full.
module issue_queue #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 96
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [DATA_W-1:0]            data_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [DATA_W-1:0]            data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH-1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_incr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign ready_o = (count_q != FULL_CNT);
  assign valid_o = (count_q != '0);
  assign data_o  = mem_q[head_q];
  assign count_o = count_q;

  assign push = valid_i && ready_o && !flush_i;
  assign pop  = valid_o && ready_i && !flush_i;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = ptr_incr(tail_q);
      if (pop)  head_d = ptr_incr(head_q);
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately left unreset; only the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[tail_q] <= data_i;
  end

endmodule

// File: doc/issue_queue.md
# issue_queue

In-order circular FIFO buffering fetched/decoded instructions between the frontend instruction selector and the issue logic of the execution pipeline. Each entry holds one instruction word together with its PC. The queue absorbs the rate mismatch between fetch and issue and is emptied in one cycle on a branch mispredict flush. Depth is any integer ≥2; the default is the global issue-queue depth.

## Interface

Parameters:
- DEPTH, default IQ_DEPTH (8): number of entries; need not be a power of 2.
- DATA_W, default XLEN+ILEN (96): entry width; {pc[95:32], instr[31:0]}.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  discard all entries (mispredict resolution).
- valid_i  in  1  upstream offers an entry.
- ready_o  out  1  queue can accept an entry this cycle.
- data_i  in  DATA_W  entry offered by upstream.
- valid_o  out  1  head entry is valid.
- ready_i  in  1  downstream consumes the head this cycle.
- data_o  out  DATA_W  head entry.
- count_o  out  $clog2(DEPTH+1)  current occupancy.

## Operation

- Storage: DEPTH × DATA_W register array; head pointer (read), tail pointer (write), occupancy counter, each $clog2(DEPTH) bits wide (counter $clog2(DEPTH+1)).
- Pointer increment: ptr+1, wrapping to 0 when ptr == DEPTH-1 (explicit compare, not modulo-2^n).
- Push = valid_i && ready_o && !flush_i: write data_i at tail, advance tail.
- Pop = valid_o && ready_i && !flush_i: advance head.
- ready_o = (count != DEPTH). Depends only on state; never on ready_i or valid_i.
- valid_o = (count != 0). data_o = array[head], combinational from storage; no bypass from data_i.
- Occupancy: count += push − pop. Simultaneous push and pop leaves count unchanged, both pointers advance.
- Full: ready_o=0; a pop in that cycle does not permit a push in the same cycle (no full-pass-through). Next cycle ready_o=1.
- Empty: valid_o=0; ready_i ignored; data_o is don't-care.
- Flush: on the edge where flush_i=1, head, tail and count go to 0; any same-cycle push or pop is discarded. Array contents not cleared.
- Reset: head=tail=count=0 immediately (asynchronous), independent of clock. Array contents are not reset.
- No internal FSM beyond the pointer/counter state; states are effectively EMPTY (count=0), PARTIAL, FULL (count=DEPTH).

## Timing

- Reset values: ready_o=1, valid_o=0, count_o=0, data_o undefined.
- Write-to-read latency: 1 cycle. Entry pushed at edge N is presented on data_o with valid_o=1 after edge N if the queue was empty.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- ready_o, valid_o, count_o are pure functions of registered state (glitch-free w.r.t. inputs).
- Flush takes effect at the next edge; ready_o=1, valid_o=0 the cycle after.
- Asynchronous reset asserted mid-operation clears outputs without waiting for clk_i; deassertion is assumed synchronised externally.
- Order: strict FIFO; entries popped in push order across pointer wrap.

## Test plan

- Reset then fill: push 8 entries pc=0x0..0x1C, instr=0x13 with ready_i=0 → count_o goes 1..8, ready_o=0 after the 8th, valid_o=1 from cycle after first push; extra valid_i is not accepted.
- Drain order: from full, ready_i=1 for 8 cycles → data_o pc sequence 0x0,0x4,…,0x1C, then valid_o=0, count_o=0, ready_o=1.
- Wrap-around streaming: continuous push+pop for 20 cycles at count=3 → count_o stays 3, output order equals input order through two pointer wraps.
- Full-boundary simultaneous: at count=8 assert valid_i and ready_i → pop occurs, push rejected, count_o=7; next cycle push accepted, count_o back to 7 with push+pop.
- Flush: count=5, assert flush_i with valid_i=1 and ready_i=1 → next cycle count_o=0, valid_o=0, ready_o=1; the flush-cycle entry is never output.
- Reset mid-operation plus non-power-of-2: DEPTH=6, push 4, assert rst_i between edges → count_o=0 and valid_o=0 immediately; then push 10/pop 10 interleaved → correct order across wrap at index 5→0.
